fetch_unit: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline. It is the upstream producer for the decode stage:
- owns the PC register, the instruction memory and the IF/ID pipeline register;
- drives the decode stage's PC1/Instruction inputs;
- obeys the decode stage's PCen/IFIDen stall outputs;
- accepts branch/jump redirects from execute, which also flush IF/ID.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/instr_mem.sv | 27 ++
 rtl/fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Constants shared by the RISC-V pipeline stages.
// Widths, the canonical NOP encoding and the sequential PC step.
package riscv_pkg;
  localparam int              XLEN      = 32;
  localparam int              ILEN      = 32;
  localparam int              PC_INC    = 4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x 32 words, asynchronous read, synchronous write.
// A write is visible to the read port only from the cycle after the edge.
module instr_mem
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [ILEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [ILEN-1:0] rdata_o
);

  logic [ILEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// A redirect from execute beats any stall and flushes IF/ID to a bubble.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               width    = XLEN,
  parameter int               DEPTH    = 256,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCen,
  input  logic             IFIDen,
  input  logic             BranchTaken,
  input  logic [width-1:0] BranchTarget,
  input  logic             imem_we,
  input  logic [width-1:0] imem_addr,
  input  logic [width-1:0] imem_wdata,
  output logic [width-1:0] PC_current,
  output logic [width-1:0] PC1,
  output logic [width-1:0] Instruction,
  output logic             ifid_valid,
  output logic             fetch_misaligned
);

  localparam int AW = $clog2(DEPTH);

  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] pc1_q, pc1_d;
  logic [width-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [ILEN-1:0]  rdata;

  // Only the word-index bits address the array; the rest wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[width-1:AW+2], imem_addr[1:0]};

  instr_mem #(
    .DEPTH (DEPTH)
  ) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (imem_addr[AW+1:2]),
    .wdata_i (ILEN'(imem_wdata)),
    .raddr_i (pc_q[AW+1:2]),
    .rdata_o (rdata)
  );

  always_comb begin
    pc_d = pc_q;
    if (BranchTaken) begin
      pc_d = BranchTarget;
    end else if (PCen) begin
      pc_d = pc_q + width'(PC_INC);
    end
  end

  always_comb begin
    pc1_d   = pc1_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (BranchTaken) begin
      pc1_d   = '0;
      instr_d = width'(NOP_INSTR);
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (IFIDen) begin
      pc1_d   = pc_q;
      instr_d = width'(rdata);
      valid_d = 1'b1;
      mis_d   = |pc_q[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc1_q   <= '0;
      instr_q <= width'(NOP_INSTR);
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign PC_current       = pc_q;
  assign PC1              = pc1_q;
  assign Instruction      = instr_q;
  assign ifid_valid       = valid_q;
  assign fetch_misaligned = mis_q;

endmodule
